// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the RV32I hazard/forwarding controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LDU  = 2'd1,
    MCW  = 2'd2,
    MEMW = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [1:0] WB_LOAD = 2'b10;

  localparam int ST_PC    = 0;
  localparam int ST_IFID  = 1;
  localparam int ST_IDEX  = 2;
  localparam int ST_EXMEM = 3;

  localparam int FL_IFID  = 0;
  localparam int FL_IDEX  = 1;
  localparam int FL_EXMEM = 2;
  localparam int FL_MEMWB = 3;

  localparam logic [3:0] STALL_NONE  = 4'b0000;
  localparam logic [3:0] STALL_FRONT = 4'((1 << ST_PC) | (1 << ST_IFID) | (1 << ST_IDEX));
  localparam logic [3:0] STALL_ALL   = 4'(STALL_FRONT | (1 << ST_EXMEM));

  localparam logic [3:0] FLUSH_NONE   = 4'b0000;
  localparam logic [3:0] FLUSH_EXMEM  = 4'(1 << FL_EXMEM);
  localparam logic [3:0] FLUSH_MEMWB  = 4'(1 << FL_MEMWB);
  localparam logic [3:0] FLUSH_BRANCH = 4'((1 << FL_IFID) | (1 << FL_IDEX) | (1 << FL_EXMEM));

endpackage

// File: rtl/hazard_unit_v2_if.sv
// rtl/hazard_unit_v2_if.sv - pipeline-side signal bundle of the hazard controller
interface hazard_unit_v2_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] id_ex_rs1addr;
  logic [ADDR_W-1:0] id_ex_rs2addr;
  logic              id_ex_rs1used;
  logic              id_ex_rs2used;
  logic              id_ex_mcstart;
  logic              mc_done;
  logic [ADDR_W-1:0] ex_mem_rdaddr;
  logic              ex_mem_rdwren;
  logic [1:0]        ex_mem_wbsel;
  logic              ex_mem_brsel;
  logic              ex_mem_dmemreq;
  logic              dmem_ack;
  logic [ADDR_W-1:0] mem_wb_rdaddr;
  logic              mem_wb_rdwren;
  logic [3:0]        stall;
  logic [3:0]        flush;
  logic [1:0]        fwd_rs1sel;
  logic [1:0]        fwd_rs2sel;
  logic              mc_kill;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_ex_rs1addr, id_ex_rs2addr, id_ex_rs1used, id_ex_rs2used, id_ex_mcstart,
           mc_done, ex_mem_rdaddr, ex_mem_rdwren, ex_mem_wbsel, ex_mem_brsel,
           ex_mem_dmemreq, dmem_ack, mem_wb_rdaddr, mem_wb_rdwren,
    input  stall, flush, fwd_rs1sel, fwd_rs2sel, mc_kill, stall_cnt
  );

  modport slave (
    input  id_ex_rs1addr, id_ex_rs2addr, id_ex_rs1used, id_ex_rs2used, id_ex_mcstart,
           mc_done, ex_mem_rdaddr, ex_mem_rdwren, ex_mem_wbsel, ex_mem_brsel,
           ex_mem_dmemreq, dmem_ack, mem_wb_rdaddr, mem_wb_rdwren,
    output stall, flush, fwd_rs1sel, fwd_rs2sel, mc_kill, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - RAW comparator between one producer rd and one consumer rs
module hazard_match #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              rdwren_i,
  input  logic [ADDR_W-1:0] rs_i,
  input  logic              rsused_i,
  output logic              match_o
);
  // x0 is hardwired zero, so a write to it never creates a dependency
  assign match_o = rdwren_i && rsused_i && (rd_i != '0) && (rd_i == rs_i);
endmodule

// File: rtl/hazard_unit_v2.sv
// rtl/hazard_unit_v2.sv - stall/flush/forwarding controller for the 5-stage RV32I pipeline
module hazard_unit_v2
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter bit FWD_EN   = 1'b1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic             i_clk,
  input logic             i_rst_n,
  hazard_unit_v2_if.slave hz
);

  // the triggering cycle is itself the first bubble
  localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       bub_q, bub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] stall_c, flush_c;
  logic       kill_c;
  logic [1:0] fwd1_c, fwd2_c;

  logic ex_rs1, ex_rs2, wb_rs1, wb_rs2;
  logic ex_load, ldu_hit, raw_hit, mem_wait;

  hazard_match #(.ADDR_W(ADDR_W)) u_ex_rs1 (
    .rd_i(hz.ex_mem_rdaddr), .rdwren_i(hz.ex_mem_rdwren),
    .rs_i(hz.id_ex_rs1addr), .rsused_i(hz.id_ex_rs1used), .match_o(ex_rs1));
  hazard_match #(.ADDR_W(ADDR_W)) u_ex_rs2 (
    .rd_i(hz.ex_mem_rdaddr), .rdwren_i(hz.ex_mem_rdwren),
    .rs_i(hz.id_ex_rs2addr), .rsused_i(hz.id_ex_rs2used), .match_o(ex_rs2));
  hazard_match #(.ADDR_W(ADDR_W)) u_wb_rs1 (
    .rd_i(hz.mem_wb_rdaddr), .rdwren_i(hz.mem_wb_rdwren),
    .rs_i(hz.id_ex_rs1addr), .rsused_i(hz.id_ex_rs1used), .match_o(wb_rs1));
  hazard_match #(.ADDR_W(ADDR_W)) u_wb_rs2 (
    .rd_i(hz.mem_wb_rdaddr), .rdwren_i(hz.mem_wb_rdwren),
    .rs_i(hz.id_ex_rs2addr), .rsused_i(hz.id_ex_rs2used), .match_o(wb_rs2));

  assign ex_load  = (hz.ex_mem_wbsel == WB_LOAD);
  assign ldu_hit  = (ex_rs1 || ex_rs2) && ex_load;
  assign raw_hit  = ex_rs1 || ex_rs2 || wb_rs1 || wb_rs2;
  assign mem_wait = hz.ex_mem_dmemreq && !hz.dmem_ack;

  always_comb begin
    state_d = RUN;
    bub_d   = bub_q;
    stall_c = STALL_NONE;
    flush_c = FLUSH_NONE;
    kill_c  = 1'b0;
    if (mem_wait) begin
      state_d = MEMW;
      stall_c = STALL_ALL;
      flush_c = FLUSH_MEMWB;
    end else if (hz.ex_mem_brsel) begin
      bub_d   = '0;
      flush_c = FLUSH_BRANCH;
      kill_c  = (state_q == MCW);
    end else if (state_q == MCW) begin
      // on mc_done the MDU op leaves EX this edge; its mcstart must not re-arm MCW
      if (!hz.mc_done) begin
        state_d = MCW;
        stall_c = STALL_FRONT;
        flush_c = FLUSH_EXMEM;
      end
    end else if (state_q == LDU && bub_q != '0) begin
      state_d = LDU;
      bub_d   = bub_q - 3'd1;
      stall_c = STALL_FRONT;
      flush_c = FLUSH_EXMEM;
    end else if (hz.id_ex_mcstart) begin
      state_d = MCW;
      stall_c = STALL_FRONT;
      flush_c = FLUSH_EXMEM;
    end else if (FWD_EN && ldu_hit) begin
      state_d = LDU;
      bub_d   = BUB_INIT;
      stall_c = STALL_FRONT;
      flush_c = FLUSH_EXMEM;
    end else if (!FWD_EN && raw_hit) begin
      stall_c = STALL_FRONT;
      flush_c = FLUSH_EXMEM;
    end
  end

  // a load in EX/MEM has no data yet, so only non-loads forward from there
  always_comb begin
    fwd1_c = FWD_REG;
    fwd2_c = FWD_REG;
    if (FWD_EN) begin
      if (ex_rs1 && !ex_load) fwd1_c = FWD_EXMEM;
      else if (wb_rs1)        fwd1_c = FWD_MEMWB;
      if (ex_rs2 && !ex_load) fwd2_c = FWD_EXMEM;
      else if (wb_rs2)        fwd2_c = FWD_MEMWB;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c[ST_PC] && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      bub_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.stall      = stall_c;
  assign hz.flush      = flush_c;
  assign hz.mc_kill    = kill_c;
  assign hz.fwd_rs1sel = fwd1_c;
  assign hz.fwd_rs2sel = fwd2_c;
  assign hz.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_unit_v2.sv
// tb/tb_hazard_unit_v2.sv - directed self-checking bench for hazard_unit_v2
module tb_hazard_unit_v2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hazard_unit_v2_if #(.ADDR_W(5), .CNT_W(32)) hz_a ();
  hazard_unit_v2_if #(.ADDR_W(5), .CNT_W(3))  hz_b ();

  hazard_unit_v2 #(.ADDR_W(5), .FWD_EN(1'b1), .LOAD_LAT(2), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .hz(hz_a));
  hazard_unit_v2 #(.ADDR_W(5), .FWD_EN(1'b0), .LOAD_LAT(1), .CNT_W(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .hz(hz_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic idle();
    hz_a.id_ex_rs1addr = '0; hz_a.id_ex_rs2addr = '0; hz_a.id_ex_rs1used = 0; hz_a.id_ex_rs2used = 0;
    hz_a.id_ex_mcstart = 0; hz_a.mc_done = 0; hz_a.ex_mem_rdaddr = '0; hz_a.ex_mem_rdwren = 0;
    hz_a.ex_mem_wbsel = 2'b00; hz_a.ex_mem_brsel = 0; hz_a.ex_mem_dmemreq = 0; hz_a.dmem_ack = 0;
    hz_a.mem_wb_rdaddr = '0; hz_a.mem_wb_rdwren = 0;
    hz_b.id_ex_rs1addr = '0; hz_b.id_ex_rs2addr = '0; hz_b.id_ex_rs1used = 0; hz_b.id_ex_rs2used = 0;
    hz_b.id_ex_mcstart = 0; hz_b.mc_done = 0; hz_b.ex_mem_rdaddr = '0; hz_b.ex_mem_rdwren = 0;
    hz_b.ex_mem_wbsel = 2'b00; hz_b.ex_mem_brsel = 0; hz_b.ex_mem_dmemreq = 0; hz_b.dmem_ack = 0;
    hz_b.mem_wb_rdaddr = '0; hz_b.mem_wb_rdwren = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL reset_stall: got %b expected %b", hz_a.stall, 4'b0000); end
    n_checks++; if (hz_a.flush !== 4'b0000) begin n_fail++; $display("FAIL reset_flush: got %b expected %b", hz_a.flush, 4'b0000); end
    n_checks++; if (hz_a.mc_kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %b expected 0", hz_a.mc_kill); end
    n_checks++; if (hz_a.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", hz_a.stall_cnt); end
    n_checks++; if (hz_a.fwd_rs1sel !== 2'b00 || hz_a.fwd_rs2sel !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b/%b expected 00/00", hz_a.fwd_rs1sel, hz_a.fwd_rs2sel); end
    n_checks++; if (hz_b.stall_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt_b: got %0d expected 0", hz_b.stall_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    do_reset();
    hz_a.ex_mem_rdaddr = 5'd5; hz_a.ex_mem_rdwren = 1; hz_a.ex_mem_wbsel = 2'b00;
    hz_a.mem_wb_rdaddr = 5'd5; hz_a.mem_wb_rdwren = 1;
    hz_a.id_ex_rs1addr = 5'd5; hz_a.id_ex_rs1used = 1;
    #1;
    n_checks++; if (hz_a.fwd_rs1sel !== 2'b01) begin n_fail++; $display("FAIL fwd_exmem_prio: got %b expected %b", hz_a.fwd_rs1sel, 2'b01); end
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL fwd_nostall: got %b expected %b", hz_a.stall, 4'b0000); end
    n_checks++; if (hz_a.fwd_rs2sel !== 2'b00) begin n_fail++; $display("FAIL fwd_rs2_unused: got %b expected %b", hz_a.fwd_rs2sel, 2'b00); end
    tick();
    hz_a.ex_mem_rdwren = 0;
    hz_a.id_ex_rs2addr = 5'd5; hz_a.id_ex_rs2used = 1;
    #1;
    n_checks++; if (hz_a.fwd_rs1sel !== 2'b10) begin n_fail++; $display("FAIL fwd_memwb_rs1: got %b expected %b", hz_a.fwd_rs1sel, 2'b10); end
    n_checks++; if (hz_a.fwd_rs2sel !== 2'b10) begin n_fail++; $display("FAIL fwd_memwb_rs2: got %b expected %b", hz_a.fwd_rs2sel, 2'b10); end
    tick();
    hz_a.ex_mem_rdaddr = 5'd0; hz_a.ex_mem_rdwren = 1; hz_a.mem_wb_rdaddr = 5'd0;
    hz_a.id_ex_rs1addr = 5'd0; hz_a.id_ex_rs2addr = 5'd0;
    #1;
    n_checks++; if (hz_a.fwd_rs1sel !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b expected %b", hz_a.fwd_rs1sel, 2'b00); end
    tick();
    hz_a.ex_mem_rdaddr = 5'd9; hz_a.mem_wb_rdaddr = 5'd9; hz_a.mem_wb_rdwren = 1;
    hz_a.id_ex_rs1addr = 5'd9; hz_a.id_ex_rs1used = 0; hz_a.id_ex_rs2used = 0;
    #1;
    n_checks++; if (hz_a.fwd_rs1sel !== 2'b00) begin n_fail++; $display("FAIL fwd_unused: got %b expected %b", hz_a.fwd_rs1sel, 2'b00); end
    n_checks++; if (hz_a.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL fwd_cnt: got %0d expected 0", hz_a.stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    hz_a.ex_mem_rdaddr = 5'd7; hz_a.ex_mem_rdwren = 1; hz_a.ex_mem_wbsel = 2'b10;
    hz_a.id_ex_rs2addr = 5'd7; hz_a.id_ex_rs2used = 1;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0111) begin n_fail++; $display("FAIL ldu_stall1: got %b expected %b", hz_a.stall, 4'b0111); end
    n_checks++; if (hz_a.flush !== 4'b0100) begin n_fail++; $display("FAIL ldu_flush1: got %b expected %b", hz_a.flush, 4'b0100); end
    n_checks++; if (hz_a.fwd_rs2sel !== 2'b00) begin n_fail++; $display("FAIL ldu_nofwd_load: got %b expected %b", hz_a.fwd_rs2sel, 2'b00); end
    tick();
    hz_a.ex_mem_rdwren = 0; hz_a.ex_mem_wbsel = 2'b00;
    hz_a.mem_wb_rdaddr = 5'd7; hz_a.mem_wb_rdwren = 1;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0111) begin n_fail++; $display("FAIL ldu_stall2: got %b expected %b", hz_a.stall, 4'b0111); end
    n_checks++; if (hz_a.flush !== 4'b0100) begin n_fail++; $display("FAIL ldu_flush2: got %b expected %b", hz_a.flush, 4'b0100); end
    tick();
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL ldu_exit_stall: got %b expected %b", hz_a.stall, 4'b0000); end
    n_checks++; if (hz_a.fwd_rs2sel !== 2'b10) begin n_fail++; $display("FAIL ldu_exit_fwd: got %b expected %b", hz_a.fwd_rs2sel, 2'b10); end
    n_checks++; if (hz_a.stall_cnt !== 32'd2) begin n_fail++; $display("FAIL ldu_cnt: got %0d expected 2", hz_a.stall_cnt); end
    tick();
    n_checks++; if (hz_a.stall !== 4'b0000 || hz_a.stall_cnt !== 32'd2) begin n_fail++; $display("FAIL ldu_after: got %b/%0d expected 0000/2", hz_a.stall, hz_a.stall_cnt); end
  endtask

  task automatic test_branch_in_mcw();
    do_reset();
    hz_a.id_ex_mcstart = 1;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0111) begin n_fail++; $display("FAIL mcw_entry: got %b expected %b", hz_a.stall, 4'b0111); end
    tick();
    n_checks++; if (hz_a.flush !== 4'b0100 || hz_a.mc_kill !== 1'b0) begin n_fail++; $display("FAIL mcw_hold: got %b/%b expected 0100/0", hz_a.flush, hz_a.mc_kill); end
    hz_a.ex_mem_brsel = 1;
    #1;
    n_checks++; if (hz_a.flush !== 4'b0111) begin n_fail++; $display("FAIL br_flush: got %b expected %b", hz_a.flush, 4'b0111); end
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL br_stall: got %b expected %b", hz_a.stall, 4'b0000); end
    n_checks++; if (hz_a.mc_kill !== 1'b1) begin n_fail++; $display("FAIL br_kill: got %b expected 1", hz_a.mc_kill); end
    tick();
    hz_a.ex_mem_brsel = 0; hz_a.id_ex_mcstart = 0;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0000 || hz_a.flush !== 4'b0000 || hz_a.mc_kill !== 1'b0) begin n_fail++; $display("FAIL br_after: got %b/%b/%b expected 0000/0000/0", hz_a.stall, hz_a.flush, hz_a.mc_kill); end
  endtask

  task automatic test_mdu_done();
    do_reset();
    hz_a.id_ex_mcstart = 1;
    tick();
    tick();
    tick();
    hz_a.mc_done = 1;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL mdu_done_stall: got %b expected %b", hz_a.stall, 4'b0000); end
    n_checks++; if (hz_a.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL mdu_cnt: got %0d expected 3", hz_a.stall_cnt); end
    tick();
    hz_a.mc_done = 0; hz_a.id_ex_mcstart = 0;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0000 || hz_a.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL mdu_after: got %b/%0d expected 0000/3", hz_a.stall, hz_a.stall_cnt); end
  endtask

  task automatic test_mem_freeze();
    do_reset();
    hz_a.ex_mem_dmemreq = 1; hz_a.dmem_ack = 0; hz_a.ex_mem_brsel = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (hz_a.stall !== 4'b1111 || hz_a.flush !== 4'b1000) begin n_fail++; $display("FAIL memw_cycle%0d: got %b/%b expected 1111/1000", i, hz_a.stall, hz_a.flush); end
      tick();
    end
    hz_a.dmem_ack = 1; hz_a.ex_mem_brsel = 0;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0000 || hz_a.flush !== 4'b0000) begin n_fail++; $display("FAIL memw_exit: got %b/%b expected 0000/0000", hz_a.stall, hz_a.flush); end
    n_checks++; if (hz_a.stall_cnt !== 32'd3) begin n_fail++; $display("FAIL memw_cnt: got %0d expected 3", hz_a.stall_cnt); end
    tick();
    hz_a.ex_mem_dmemreq = 0; hz_a.dmem_ack = 0;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL memw_after: got %b expected %b", hz_a.stall, 4'b0000); end
  endtask

  task automatic test_stall_only();
    do_reset();
    hz_b.ex_mem_rdaddr = 5'd3; hz_b.ex_mem_rdwren = 1;
    hz_b.id_ex_rs1addr = 5'd3; hz_b.id_ex_rs1used = 1;
    #1;
    n_checks++; if (hz_b.stall !== 4'b0111 || hz_b.flush !== 4'b0100) begin n_fail++; $display("FAIL so_stall1: got %b/%b expected 0111/0100", hz_b.stall, hz_b.flush); end
    n_checks++; if (hz_b.fwd_rs1sel !== 2'b00) begin n_fail++; $display("FAIL so_fwd1: got %b expected %b", hz_b.fwd_rs1sel, 2'b00); end
    tick();
    hz_b.ex_mem_rdwren = 0;
    hz_b.mem_wb_rdaddr = 5'd3; hz_b.mem_wb_rdwren = 1;
    #1;
    n_checks++; if (hz_b.stall !== 4'b0111) begin n_fail++; $display("FAIL so_stall2: got %b expected %b", hz_b.stall, 4'b0111); end
    n_checks++; if (hz_b.fwd_rs1sel !== 2'b00) begin n_fail++; $display("FAIL so_fwd2: got %b expected %b", hz_b.fwd_rs1sel, 2'b00); end
    tick();
    hz_b.mem_wb_rdwren = 0;
    #1;
    n_checks++; if (hz_b.stall !== 4'b0000) begin n_fail++; $display("FAIL so_release: got %b expected %b", hz_b.stall, 4'b0000); end
    n_checks++; if (hz_b.stall_cnt !== 3'd2) begin n_fail++; $display("FAIL so_cnt: got %0d expected 2", hz_b.stall_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    hz_b.ex_mem_rdaddr = 5'd4; hz_b.ex_mem_rdwren = 1;
    hz_b.id_ex_rs2addr = 5'd4; hz_b.id_ex_rs2used = 1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (hz_b.stall_cnt !== 3'd7) begin n_fail++; $display("FAIL cnt_saturate: got %0d expected 7", hz_b.stall_cnt); end
    idle();
  endtask

  task automatic test_reset_mid_ldu();
    do_reset();
    hz_a.ex_mem_rdaddr = 5'd7; hz_a.ex_mem_rdwren = 1; hz_a.ex_mem_wbsel = 2'b10;
    hz_a.id_ex_rs2addr = 5'd7; hz_a.id_ex_rs2used = 1;
    tick();
    hz_a.ex_mem_rdwren = 0; hz_a.ex_mem_wbsel = 2'b00;
    hz_a.mem_wb_rdaddr = 5'd7; hz_a.mem_wb_rdwren = 1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (hz_a.stall !== 4'b0000) begin n_fail++; $display("FAIL rst_ldu_stall: got %b expected %b", hz_a.stall, 4'b0000); end
    n_checks++; if (hz_a.stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_ldu_cnt: got %0d expected 0", hz_a.stall_cnt); end
    n_checks++; if (hz_a.fwd_rs2sel !== 2'b10) begin n_fail++; $display("FAIL rst_ldu_fwd: got %b expected %b", hz_a.fwd_rs2sel, 2'b10); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_in_mcw();
    test_mdu_done();
    test_mem_freeze();
    test_stall_only();
    test_saturate();
    test_reset_mid_ldu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
